// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : control_sequencer_if
// Brief  : IR/condition inputs and datapath control strobes of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface control_sequencer_if;
    logic [31:0] instruction;
    logic        con_ff;
    logic        mem_ready;

    logic        Gra, Grb, Grc;
    logic        Rin, Rout, BAout, Cout;
    logic        PCout, PCin, IncPC, IRin;
    logic        MARin, MDRin, MDRout, Read, Write;
    logic        Yin, Zin, Zhighout, Zlowout;
    logic        HIin, HIout, LOin, LOout;
    logic        InPortout, OutPortin, CONin;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  instruction, con_ff, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
               PCout, PCin, IncPC, IRin,
               MARin, MDRin, MDRout, Read, Write,
               Yin, Zin, Zhighout, Zlowout,
               HIin, HIout, LOin, LOout,
               InPortout, OutPortin, CONin, alu_op, run
    );

    modport slave (
        output instruction, con_ff, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
               PCout, PCin, IncPC, IRin,
               MARin, MDRin, MDRout, Read, Write,
               Yin, Zin, Zhighout, Zlowout,
               HIin, HIout, LOin, LOout,
               InPortout, OutPortin, CONin, alu_op, run
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : control_sequencer
// Brief  : Hardwired T-state control unit; Moore decode of state + IR[31:27].
//          Optional MEM_WAIT_EN stretches memory steps until mem_ready.
// Rev    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int         T_LAST = 7,
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  wire                 clock,
    input  wire                 reset_n,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_RST = 4'd8, S_HALT = 4'd9
    } state_t;

    localparam logic [26:0] C_GRA     = 27'h1 << 0;
    localparam logic [26:0] C_GRB     = 27'h1 << 1;
    localparam logic [26:0] C_GRC     = 27'h1 << 2;
    localparam logic [26:0] C_RIN     = 27'h1 << 3;
    localparam logic [26:0] C_ROUT    = 27'h1 << 4;
    localparam logic [26:0] C_BAOUT   = 27'h1 << 5;
    localparam logic [26:0] C_COUT    = 27'h1 << 6;
    localparam logic [26:0] C_PCOUT   = 27'h1 << 7;
    localparam logic [26:0] C_PCIN    = 27'h1 << 8;
    localparam logic [26:0] C_INCPC   = 27'h1 << 9;
    localparam logic [26:0] C_IRIN    = 27'h1 << 10;
    localparam logic [26:0] C_MARIN   = 27'h1 << 11;
    localparam logic [26:0] C_MDRIN   = 27'h1 << 12;
    localparam logic [26:0] C_MDROUT  = 27'h1 << 13;
    localparam logic [26:0] C_READ    = 27'h1 << 14;
    localparam logic [26:0] C_WRITE   = 27'h1 << 15;
    localparam logic [26:0] C_YIN     = 27'h1 << 16;
    localparam logic [26:0] C_ZIN     = 27'h1 << 17;
    localparam logic [26:0] C_ZHIGH   = 27'h1 << 18;
    localparam logic [26:0] C_ZLOW    = 27'h1 << 19;
    localparam logic [26:0] C_HIIN    = 27'h1 << 20;
    localparam logic [26:0] C_HIOUT   = 27'h1 << 21;
    localparam logic [26:0] C_LOIN    = 27'h1 << 22;
    localparam logic [26:0] C_LOOUT   = 27'h1 << 23;
    localparam logic [26:0] C_INPORT  = 27'h1 << 24;
    localparam logic [26:0] C_OUTPORT = 27'h1 << 25;
    localparam logic [26:0] C_CONIN   = 27'h1 << 26;
    localparam logic [2:0]  C_LAST_MEM = 3'(T_LAST);

    state_t      r_state, w_next;
    logic [4:0]  w_op;
    logic [2:0]  w_step, w_last;
    logic [26:0] w_st;
    logic [4:0]  w_alu_op;
    logic        w_run;
    logic        w_alu, w_imm, w_muldiv, w_negnot, w_ld, w_ldi, w_st_op, w_br;
    logic        w_jr, w_jal, w_in, w_out, w_mfhi, w_mflo, w_halt, w_noexec;
    logic        w_unused_ir;

    assign w_op        = bus.instruction[31:27];
    assign w_step      = r_state[2:0];
    assign w_unused_ir = ^bus.instruction[26:0];

    assign w_alu    = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_imm    = (w_op >= 5'd12) && (w_op <= 5'd14);
    assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_negnot = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_ld     = (w_op == 5'd0);
    assign w_ldi    = (w_op == 5'd1);
    assign w_st_op  = (w_op == 5'd2);
    assign w_br     = (w_op == 5'd19);
    assign w_jr     = (w_op == 5'd20);
    assign w_jal    = (w_op == 5'd21);
    assign w_in     = (w_op == 5'd22);
    assign w_out    = (w_op == 5'd23);
    assign w_mfhi   = (w_op == 5'd24);
    assign w_mflo   = (w_op == 5'd25);
    assign w_halt   = (w_op == 5'd27);
    assign w_noexec = (w_op == 5'd26) || (w_op >= 5'd28);

    // Final execute step per opcode class; reaching it returns to fetch.
    always_comb begin
        w_last = 3'd3;
        if (w_ld || w_st_op)                 w_last = C_LAST_MEM;
        else if (w_muldiv || w_br)           w_last = 3'd6;
        else if (w_alu || w_imm || w_ldi)    w_last = 3'd5;
        else if (w_negnot || w_jal)          w_last = 3'd4;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_RST;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:      w_next = S_T0;
            S_HALT:     w_next = S_HALT;
            S_T0, S_T1: w_next = state_t'(r_state + 4'd1);
            S_T2: begin
                if (w_halt)        w_next = S_HALT;
                else if (w_noexec) w_next = S_T0;
                else               w_next = S_T3;
            end
            default:    w_next = (w_step == w_last) ? S_T0 : state_t'(r_state + 4'd1);
        endcase
`ifdef MEM_WAIT_EN
        if (((r_state == S_T1) || (w_ld && r_state == S_T6) ||
             (w_st_op && r_state == S_T7)) && !bus.mem_ready)
            w_next = r_state;
`endif
    end

`ifndef MEM_WAIT_EN
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = bus.mem_ready;
`endif

    always_comb begin
        w_st     = '0;
        w_alu_op = '0;
        w_run    = (r_state != S_HALT);
        case (r_state)
            S_T0: w_st = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
            S_T1: w_st = C_ZLOW | C_PCIN | C_READ | C_MDRIN;
            S_T2: w_st = C_MDROUT | C_IRIN;
            S_T3: begin
                if (w_alu || w_imm)                 w_st = C_GRB | C_ROUT | C_YIN;
                else if (w_negnot) begin
                    w_st     = C_GRB | C_ROUT | C_ZIN;
                    w_alu_op = w_op;
                end
                else if (w_muldiv)                  w_st = C_GRA | C_ROUT | C_YIN;
                else if (w_ld || w_ldi || w_st_op)  w_st = C_GRB | C_BAOUT | C_YIN;
                else if (w_br)                      w_st = C_GRA | C_ROUT | C_CONIN;
                else if (w_jr)                      w_st = C_GRA | C_ROUT | C_PCIN;
                else if (w_jal)                     w_st = C_PCOUT | C_GRB | C_RIN;
                else if (w_in)                      w_st = C_GRA | C_RIN | C_INPORT;
                else if (w_out)                     w_st = C_GRA | C_ROUT | C_OUTPORT;
                else if (w_mfhi)                    w_st = C_GRA | C_RIN | C_HIOUT;
                else if (w_mflo)                    w_st = C_GRA | C_RIN | C_LOOUT;
            end
            S_T4: begin
                if (w_alu || w_muldiv) begin
                    w_st     = (w_alu ? C_GRC : C_GRB) | C_ROUT | C_ZIN;
                    w_alu_op = w_op;
                end
                else if (w_imm) begin
                    w_st     = C_COUT | C_ZIN;
                    w_alu_op = w_op;
                end
                else if (w_ld || w_ldi || w_st_op) begin
                    w_st     = C_COUT | C_ZIN;
                    w_alu_op = ADD_OP;
                end
                else if (w_negnot)                  w_st = C_ZLOW | C_GRA | C_RIN;
                else if (w_br)                      w_st = C_PCOUT | C_YIN;
                else if (w_jal)                     w_st = C_GRA | C_ROUT | C_PCIN;
            end
            S_T5: begin
                if (w_alu || w_imm || w_ldi)        w_st = C_ZLOW | C_GRA | C_RIN;
                else if (w_muldiv)                  w_st = C_ZLOW | C_LOIN;
                else if (w_ld || w_st_op)           w_st = C_ZLOW | C_MARIN;
                else if (w_br) begin
                    w_st     = C_COUT | C_ZIN;
                    w_alu_op = ADD_OP;
                end
            end
            S_T6: begin
                if (w_muldiv)                       w_st = C_ZHIGH | C_HIIN;
                else if (w_ld)                      w_st = C_READ | C_MDRIN;
                else if (w_st_op)                   w_st = C_GRA | C_ROUT | C_MDRIN;
                else if (w_br && bus.con_ff)        w_st = C_ZLOW | C_PCIN;
            end
            S_T7: begin
                if (w_ld)                           w_st = C_MDROUT | C_GRA | C_RIN;
                else if (w_st_op)                   w_st = C_WRITE;
            end
            default: w_st = '0;
        endcase
    end

    assign {bus.CONin, bus.OutPortin, bus.InPortout, bus.LOout, bus.LOin,
            bus.HIout, bus.HIin, bus.Zlowout, bus.Zhighout, bus.Zin, bus.Yin,
            bus.Write, bus.Read, bus.MDRout, bus.MDRin, bus.MARin, bus.IRin,
            bus.IncPC, bus.PCin, bus.PCout, bus.Cout, bus.BAout, bus.Rout,
            bus.Rin, bus.Grc, bus.Grb, bus.Gra} = w_st;
    assign bus.alu_op = w_alu_op;
    assign bus.run    = w_run;
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_control_sequencer
// Brief  : Checks the sequencer cycle by cycle against per-opcode step tables.
// Rev    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer #(.T_LAST(7), .ADD_OP(5'b00011)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    localparam logic [26:0] GRA = 27'h1 << 0,  GRB = 27'h1 << 1,  GRC = 27'h1 << 2;
    localparam logic [26:0] RIN = 27'h1 << 3,  ROUT = 27'h1 << 4, BAOUT = 27'h1 << 5;
    localparam logic [26:0] COUT = 27'h1 << 6, PCOUT = 27'h1 << 7, PCIN = 27'h1 << 8;
    localparam logic [26:0] INCPC = 27'h1 << 9, IRIN = 27'h1 << 10, MARIN = 27'h1 << 11;
    localparam logic [26:0] MDRIN = 27'h1 << 12, MDROUT = 27'h1 << 13, READ = 27'h1 << 14;
    localparam logic [26:0] WRITE = 27'h1 << 15, YIN = 27'h1 << 16, ZIN = 27'h1 << 17;
    localparam logic [26:0] ZHIGH = 27'h1 << 18, ZLOW = 27'h1 << 19, HIIN = 27'h1 << 20;
    localparam logic [26:0] HIOUT = 27'h1 << 21, LOIN = 27'h1 << 22, LOOUT = 27'h1 << 23;
    localparam logic [26:0] INPORT = 27'h1 << 24, OUTPORT = 27'h1 << 25, CONIN = 27'h1 << 26;
    localparam logic [26:0] FETCH0 = PCOUT | MARIN | INCPC | ZIN;

    logic [26:0] obs;
    assign obs = {bus.CONin, bus.OutPortin, bus.InPortout, bus.LOout, bus.LOin,
                  bus.HIout, bus.HIin, bus.Zlowout, bus.Zhighout, bus.Zin, bus.Yin,
                  bus.Write, bus.Read, bus.MDRout, bus.MDRin, bus.MARin, bus.IRin,
                  bus.IncPC, bus.PCin, bus.PCout, bus.Cout, bus.BAout, bus.Rout,
                  bus.Rin, bus.Grc, bus.Grb, bus.Gra};

    typedef struct packed {
        logic [26:0] st;
        logic [4:0]  op;
        logic        mem;
    } step_t;

    step_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [26:0] s, input logic [4:0] o, input logic m);
        exp_q.push_back({s, o, m});
    endfunction

    // Expected per-cycle strobes of one instruction, from T0 until its last step.
    function automatic void build(input logic [4:0] op, input logic con);
        exp_q.delete();
        push(FETCH0, 5'd0, 1'b0);
        push(ZLOW | PCIN | READ | MDRIN, 5'd0, 1'b1);
        push(MDROUT | IRIN, 5'd0, 1'b0);
        if (op >= 5'd3 && op <= 5'd11) begin
            push(GRB | ROUT | YIN, 5'd0, 1'b0);
            push(GRC | ROUT | ZIN, op, 1'b0);
            push(ZLOW | GRA | RIN, 5'd0, 1'b0);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(GRB | ROUT | YIN, 5'd0, 1'b0);
            push(COUT | ZIN, op, 1'b0);
            push(ZLOW | GRA | RIN, 5'd0, 1'b0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(GRB | ROUT | ZIN, op, 1'b0);
            push(ZLOW | GRA | RIN, 5'd0, 1'b0);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(GRA | ROUT | YIN, 5'd0, 1'b0);
            push(GRB | ROUT | ZIN, op, 1'b0);
            push(ZLOW | LOIN, 5'd0, 1'b0);
            push(ZHIGH | HIIN, 5'd0, 1'b0);
        end else if (op <= 5'd2) begin
            push(GRB | BAOUT | YIN, 5'd0, 1'b0);
            push(COUT | ZIN, 5'd3, 1'b0);
            if (op == 5'd1) begin
                push(ZLOW | GRA | RIN, 5'd0, 1'b0);
            end else begin
                push(ZLOW | MARIN, 5'd0, 1'b0);
                if (op == 5'd0) begin
                    push(READ | MDRIN, 5'd0, 1'b1);
                    push(MDROUT | GRA | RIN, 5'd0, 1'b0);
                end else begin
                    push(GRA | ROUT | MDRIN, 5'd0, 1'b0);
                    push(WRITE, 5'd0, 1'b1);
                end
            end
        end else if (op == 5'd19) begin
            push(GRA | ROUT | CONIN, 5'd0, 1'b0);
            push(PCOUT | YIN, 5'd0, 1'b0);
            push(COUT | ZIN, 5'd3, 1'b0);
            push(con ? (ZLOW | PCIN) : 27'd0, 5'd0, 1'b0);
        end else if (op == 5'd20) push(GRA | ROUT | PCIN, 5'd0, 1'b0);
        else if (op == 5'd21) begin
            push(PCOUT | GRB | RIN, 5'd0, 1'b0);
            push(GRA | ROUT | PCIN, 5'd0, 1'b0);
        end
        else if (op == 5'd22) push(GRA | RIN | INPORT, 5'd0, 1'b0);
        else if (op == 5'd23) push(GRA | ROUT | OUTPORT, 5'd0, 1'b0);
        else if (op == 5'd24) push(GRA | RIN | HIOUT, 5'd0, 1'b0);
        else if (op == 5'd25) push(GRA | RIN | LOOUT, 5'd0, 1'b0);
    endfunction

    // Runs one instruction from T0; memory steps see w cycles of mem_ready=0.
    task automatic exec_instr(input logic [31:0] ir, input logic con, input int w, input string tag);
        bus.instruction = ir;
        bus.con_ff      = con;
        build(ir[31:27], con);
        for (int i = 0; i < exp_q.size(); i++) begin
            int reps;
            reps = 1;
`ifdef MEM_WAIT_EN
            if (exp_q[i].mem) reps = w + 1;
`endif
            for (int k = 0; k < reps; k++) begin
                if (exp_q[i].mem) begin
`ifdef MEM_WAIT_EN
                    bus.mem_ready = (k >= w);
`else
                    bus.mem_ready = (w == 0);
`endif
                end else begin
                    bus.mem_ready = 1'($urandom);
                end
                n_tests++;
                if ({bus.run, bus.alu_op, obs} !== {1'b1, exp_q[i].op, exp_q[i].st}) begin
                    n_fail++;
                    $display("FAIL %s step%0d: got run=%b alu_op=%h strobes=%h, want run=1 alu_op=%h strobes=%h",
                             tag, i, bus.run, bus.alu_op, obs, exp_q[i].op, exp_q[i].st);
                end
                tick();
            end
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instruction = 32'd0;
        bus.con_ff = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        n_tests++;
        if ({bus.run, bus.alu_op, obs} !== {1'b1, 5'd0, 27'd0}) begin
            n_fail++;
            $display("FAIL reset_hold: got run=%b alu_op=%h strobes=%h, want run=1 0 0", bus.run, bus.alu_op, obs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({bus.run, obs} !== {1'b1, FETCH0}) begin
            n_fail++;
            $display("FAIL reset_to_t0: got run=%b strobes=%h, want run=1 strobes=%h", bus.run, obs, FETCH0);
        end
    endtask

    task automatic test_reset_mid();
        bus.instruction = 32'h18918000;
        repeat (4) tick();
        n_tests++;
        if ({bus.alu_op, obs} !== {5'd3, GRC | ROUT | ZIN}) begin
            n_fail++;
            $display("FAIL mid_t4: got alu_op=%h strobes=%h, want alu_op=03 strobes=%h", bus.alu_op, obs, GRC | ROUT | ZIN);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.run, bus.alu_op, obs} !== {1'b1, 5'd0, 27'd0}) begin
            n_fail++;
            $display("FAIL async_abort: got run=%b alu_op=%h strobes=%h, want run=1 0 0", bus.run, bus.alu_op, obs);
        end
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.run, obs} !== {1'b1, 27'd0}) begin
            n_fail++;
            $display("FAIL rst_state: got run=%b strobes=%h, want run=1 strobes=0", bus.run, obs);
        end
        tick();
        n_tests++;
        if (obs !== FETCH0) begin
            n_fail++;
            $display("FAIL restart_t0: got strobes=%h, want %h", obs, FETCH0);
        end
    endtask

    task automatic test_directed();
        exec_instr(32'h18918000, 1'b0, 0, "add");
        exec_instr(32'h10800014, 1'b0, 0, "st");
        exec_instr(32'h10800014, 1'b0, 3, "st_wait3");
        exec_instr(32'h00800014, 1'b1, 2, "ld_wait2");
        exec_instr(32'h98800010, 1'b0, 0, "br_nottaken");
        exec_instr(32'h98800010, 1'b1, 0, "br_taken");
        exec_instr(32'h78900000, 1'b0, 0, "mul");
        exec_instr(32'hD0000000, 1'b0, 0, "nop");
        exec_instr(32'hF8000000, 1'b0, 0, "undef");
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            exec_instr({op, 27'($urandom)}, 1'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_halt();
        exec_instr(32'hD8000000, 1'b0, 0, "halt_fetch");
        for (int c = 0; c < 20; c++) begin
            bus.instruction = $urandom;
            bus.con_ff      = 1'($urandom);
            bus.mem_ready   = 1'($urandom);
            n_tests++;
            if ({bus.run, bus.alu_op, obs} !== 33'd0) begin
                n_fail++;
                $display("FAIL halt_cycle%0d: got run=%b alu_op=%h strobes=%h, want all 0", c, bus.run, bus.alu_op, obs);
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.run, obs} !== {1'b1, 27'd0}) begin
            n_fail++;
            $display("FAIL halt_reset: got run=%b strobes=%h, want run=1 strobes=0", bus.run, obs);
        end
        tick();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        exec_instr(32'h18918000, 1'b0, 0, "after_halt");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back_random();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the 32-bit, 16-register datapath.
- Steps a T-state machine (fetch T0–T2, execute T3–T7) and decodes IR[31:27].
- Each cycle it drives the select/encode strobes (Gra/Grb/Grc, Rin, Rout, BAout), the bus-source/load strobes, the ALU op and the memory Read/Write.
- Sits between the IR and the datapath. It is the only sequencer of the register-file select logic.

Parameters:
- T_LAST, 7, highest execute step index; step counter width is 3 bits.
- ADD_OP, 5'b00011, ALU op code driven during effective-address and branch-target add.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- instruction  input  32  IR contents; opcode [31:27]
- con_ff  input  1  branch-condition flip-flop output
- mem_ready  input  1  memory done; used only with MEM_WAIT_EN
- Gra, Grb, Grc  output  1 each  register-field select strobes
- Rin, Rout, BAout, Cout  output  1 each  register-file load/drive, base-address drive, sign-extended C drive
- PCout, PCin, IncPC, IRin  output  1 each  program counter / IR strobes
- MARin, MDRin, MDRout, Read, Write  output  1 each  memory interface strobes
- Yin, Zin, Zhighout, Zlowout  output  1 each  ALU operand/result strobes
- HIin, HIout, LOin, LOout  output  1 each  HI/LO register strobes
- InPortout, OutPortin, CONin  output  1 each  I/O port and condition-logic strobes
- alu_op  output  5  ALU operation
- run  output  1  high unless halted

Behaviour:
- States: RST, T0..T7, HALT. Outputs are a Moore decode of state plus IR opcode, registered only via the state.
- Reset (async, reset_n=0): state=RST. Every strobe=0, alu_op=0, run=1. First rising edge after release: RST→T0. Reset mid-instruction aborts it immediately; no Write may be asserted in RST.
- Fetch, all opcodes:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute, T3 onward by opcode. Final listed step returns to T0.
  - R-ALU (00011–01011): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
  - Immediate (addi 01100, andi 01101, ori 01110): T3 Grb,Rout,Yin; T4 Cout,Zin,alu_op=opcode; T5 Zlowout,Gra,Rin.
  - neg 10001 / not 10010: T3 Grb,Rout,Zin,alu_op=opcode; T4 Zlowout,Gra,Rin.
  - mul 01111 / div 10000: T3 Gra,Rout,Yin; T4 Grb,Rout,Zin,alu_op=opcode; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - ld 00000:
    - T3 Grb,BAout,Yin; T4 Cout,Zin,alu_op=ADD_OP; T5 Zlowout,MARin.
    - T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - ldi 00001: T3–T4 as ld; T5 Zlowout,Gra,Rin.
  - st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin; T7 Write.
  - br 10011:
    - T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,alu_op=ADD_OP.
    - T6 Zlowout,PCin only if con_ff=1, else no strobes.
  - jr 10100: T3 Gra,Rout,PCin.
  - jal 10101: T3 PCout,Grb,Rin; T4 Gra,Rout,PCin.
  - in 10110: T3 Gra,Rin,InPortout.
  - out 10111: T3 Gra,Rout,OutPortin.
  - mfhi 11000: T3 Gra,Rin,HIout.
  - mflo 11001: T3 Gra,Rin,LOout.
  - nop 11010 and undefined 11100–11111: T2→T0.
  - halt 11011: T2→HALT. HALT is absorbing until reset; all strobes 0, run=0.
- At most one of Gra/Grb/Grc is high in any state; at most one bus driver is high.
- alu_op=0 whenever Zin=0.

Optional Feature:
- Macro MEM_WAIT_EN.
- Defined: in T1 (fetch), ld T6 and st T7 the state holds while mem_ready=0, with Read/MDRin or Write kept asserted every cycle. It advances on the first cycle mem_ready=1.
- Undefined: mem_ready is ignored and every memory step is exactly one cycle.

Test Plan:
- Reset: reset_n=0 mid-T4 of add → all strobes 0 immediately. Release → RST one cycle, then T0 with PCout=MARin=IncPC=Zin=1.
- add, IR=0x18918000 (Ra=1, Rb=2, Rc=3): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=00011; T5 Gra,Rin,Zlowout; next cycle T0. Total 6 cycles.
- st, IR=0x10800014: T4 Cout,alu_op=00011; T7 Write=1 exactly one cycle. With MEM_WAIT_EN and mem_ready low 3 cycles, Write is held 4 cycles.
- br: con_ff=0 → T6 has PCin=0. con_ff=1 → T6 Zlowout=PCin=1. Both return to T0.
- mul, IR=0x78900000: LOin in T5, HIin in T6, never both in the same cycle.
- halt, IR=0xD8000000: after T2, run=0, all strobes 0 for 20 cycles. reset_n pulse → run=1, fetch resumes.
